// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Instruction-memory bus between the fetch stage and instruction memory.
// Request/grant for issue, followed by an in-order response-valid beat.
//   imem_req    fetch -> mem  request valid
//   imem_addr   fetch -> mem  word-aligned fetch address
//   imem_gnt    mem -> fetch  request accepted this cycle
//   imem_rvalid mem -> fetch  response valid (at most one per issue)
//   imem_rdata  mem -> fetch  response word
// -----------------------------------------------------------------------------
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage. Holds the PC, issues one word request at a time to
// instruction memory and buffers returned words in a 2-entry FIFO that feeds
// decode. A PCSrc redirect flushes the FIFO and squashes any in-flight fetch.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem (master)       instruction-memory request/grant/response bus
//   PCSrc, PCTarget     redirect request and target (low two bits ignored)
//   Instr, InstrPC      FIFO head word and its PC (NOP_INSTR / 0 when empty)
//   instr_valid         FIFO non-empty
//   instr_ready         decode consumes the head
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_if.master        imem,
  input  logic                 PCSrc,
  input  logic [31:0]          PCTarget,
  output logic [31:0]          Instr,
  output logic [31:0]          InstrPC,
  output logic                 instr_valid,
  input  logic                 instr_ready
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        outstanding_q, outstanding_d;
  logic        discard_q, discard_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic [31:0] fifo_pc_q  [2];
  logic [31:0] fifo_pc_d  [2];
  logic [31:0] fifo_ins_q [2];
  logic [31:0] fifo_ins_d [2];

  logic        issue_s;
  logic        resp_s;
  logic        push_s;
  logic        pop_s;
  logic        kept_s;
  logic        tail_s;
  logic [1:0]  count_nx_s;

  // Next-state, datapath and FSM transition logic.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    out_pc_d      = out_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    head_d        = head_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_ins_d    = fifo_ins_q;

    // req_q is only ever high in S_REQ, which implies nothing in flight and
    // room for the returning word, so a push can never hit a full FIFO.
    issue_s    = req_q & imem.imem_gnt;
    resp_s     = imem.imem_rvalid & outstanding_q;
    push_s     = resp_s & ~discard_q;
    pop_s      = (count_q != 2'd0) & instr_ready;
    // A request survives a redirect if it was in flight and its response did
    // not land this cycle, or if it is being issued right now.
    kept_s     = (outstanding_q & ~imem.imem_rvalid) | issue_s;
    tail_s     = head_q ^ count_q[0];
    count_nx_s = count_q + {1'b0, push_s} - {1'b0, pop_s};

    if (PCSrc) begin
      fetch_pc_d    = {PCTarget[31:2], 2'b00};
      count_d       = 2'd0;
      outstanding_d = kept_s;
      discard_d     = kept_s;
      if (kept_s) begin
        state_d = S_WAIT;
      end else begin
        state_d = S_REQ;
      end
    end else begin
      if (issue_s) begin
        out_pc_d      = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
        outstanding_d = 1'b1;
      end else begin
        out_pc_d = out_pc_q;
      end

      if (resp_s) begin
        outstanding_d = 1'b0;
        if (discard_q) begin
          discard_d = 1'b0;
        end else begin
          fifo_pc_d[tail_s]  = out_pc_q;
          fifo_ins_d[tail_s] = imem.imem_rdata;
        end
      end else begin
        discard_d = discard_q;
      end

      if (pop_s) begin
        head_d = ~head_q;
      end else begin
        head_d = head_q;
      end

      count_d = count_nx_s;

      case (state_q)
        S_REQ: begin
          if (issue_s) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (!resp_s) begin
            state_d = S_WAIT;
          end else if (count_nx_s == 2'd2) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_REQ;
          end
        end
        S_HOLD: begin
          if (count_nx_s == 2'd2) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_REQ;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end

    // Request is registered: it follows the state being entered.
    req_d = (state_d == S_REQ);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      req_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      out_pc_q      <= 32'h0000_0000;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      count_q       <= 2'd0;
      head_q        <= 1'b0;
      fifo_pc_q[0]  <= 32'h0000_0000;
      fifo_pc_q[1]  <= 32'h0000_0000;
      fifo_ins_q[0] <= 32'h0000_0000;
      fifo_ins_q[1] <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      fetch_pc_q    <= fetch_pc_d;
      out_pc_q      <= out_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      head_q        <= head_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_ins_q    <= fifo_ins_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = fetch_pc_q;

  // Decode-side view of the FIFO head; depends on registers only.
  always_comb begin
    if (count_q != 2'd0) begin
      Instr       = fifo_ins_q[head_q];
      InstrPC     = fifo_pc_q[head_q];
      instr_valid = 1'b1;
    end else begin
      Instr       = NOP_INSTR;
      InstrPC     = 32'h0000_0000;
      instr_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed scenarios followed by a randomized run of instr_fetch, compared
// every cycle against a queue-based reference model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        instr_valid;
  logic        instr_ready;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget),
    .Instr       (Instr),
    .InstrPC     (InstrPC),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_fetch;
  logic [31:0] m_out_pc;
  bit          m_out;
  bit          m_disc;
  bit          m_req;
  logic [63:0] m_q[$];     // {pc, instr}, head at index 0

  // Memory-side bookkeeping: addresses issued and not yet answered
  logic [31:0] pend[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fetch  = RESET_PC;
    m_out_pc = 32'h0;
    m_out    = 1'b0;
    m_disc   = 1'b0;
    m_req    = 1'b0;
    m_q.delete();
  endtask

  task automatic check_outputs();
    logic [63:0] head;
    chk1("imem_req", bus.imem_req, m_req);
    chk("imem_addr", bus.imem_addr, m_fetch);
    if (m_q.size() > 0) begin
      head = m_q[0];
      chk1("instr_valid", instr_valid, 1'b1);
      chk("Instr", Instr, head[31:0]);
      chk("InstrPC", InstrPC, head[63:32]);
    end else begin
      chk1("instr_valid", instr_valid, 1'b0);
      chk("Instr", Instr, NOP_INSTR);
      chk("InstrPC", InstrPC, 32'h0);
    end
  endtask

  task automatic model_edge(input logic g, input logic rv, input logic [31:0] rd,
                            input logic rdy, input logic ps, input logic [31:0] tgt);
    bit          issue;
    bit          resp;
    bit          kept;
    logic [63:0] dropped;
    issue = m_req && g;
    resp  = rv && m_out;
    if (ps) begin
      kept = (m_out && !rv) || issue;
      m_q.delete();
      m_fetch = {tgt[31:2], 2'b00};
      m_out   = kept;
      m_disc  = kept;
    end else begin
      if (m_q.size() > 0 && rdy) dropped = m_q.pop_front();
      if (issue) begin
        m_out_pc = m_fetch;
        m_fetch  = m_fetch + 32'd4;
        m_out    = 1'b1;
      end
      if (resp) begin
        m_out = 1'b0;
        if (m_disc) m_disc = 1'b0;
        else m_q.push_back({m_out_pc, rd});
      end
    end
    m_req = !m_out && (m_q.size() < 2);
  endtask

  // One clock cycle: check at the negedge, drive inputs, advance model at the
  // posedge, return at the next negedge.
  task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                      input logic rdy, input logic ps, input logic [31:0] tgt);
    logic        was_req;
    logic [31:0] was_addr;
    logic [31:0] dropped;
    check_outputs();
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    instr_ready     = rdy;
    PCSrc           = ps;
    PCTarget        = tgt;
    was_req         = bus.imem_req;
    was_addr        = bus.imem_addr;
    @(posedge clk);
    model_edge(g, rv, rd, rdy, ps, tgt);
    if (rv && pend.size() > 0) dropped = pend.pop_front();
    if (was_req && g) pend.push_back(was_addr);
    @(negedge clk);
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    PCSrc           = 1'b0;
  endtask

  // Asynchronous reset pulse in mid-cycle; outputs checked before any edge.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk1("rst_req", bus.imem_req, 1'b0);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", Instr, NOP_INSTR);
    chk("rst_instrpc", InstrPC, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic        g;
    logic        rv;
    logic [31:0] rd;
    rst_n           = 1'b0;
    PCSrc           = 1'b0;
    PCTarget        = 32'h0;
    instr_ready     = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk1("init_req", bus.imem_req, 1'b0);
    chk("init_instr", Instr, NOP_INSTR);
    rst_n = 1'b1;

    // First fetch with zero-wait memory
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1("first_req", bus.imem_req, 1'b1);
    chk("first_addr", bus.imem_addr, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1("wait_req", bus.imem_req, 1'b0);
    step(1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
    chk("t1_instr", Instr, 32'h0050_0093);
    chk("t1_pc", InstrPC, 32'h0);
    chk1("t1_valid", instr_valid, 1'b1);
    chk("t1_addr", bus.imem_addr, 32'h4);

    // Fill the FIFO with decode stalled, then drain
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h00A0_0113, 1'b0, 1'b0, 32'h0);
    chk1("hold_req", bus.imem_req, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1("hold_req2", bus.imem_req, 1'b0);
    chk("hold_pc", InstrPC, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("pop1_pc", InstrPC, 32'h4);
    chk("pop1_instr", Instr, 32'h00A0_0113);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk1("drain_valid", instr_valid, 1'b0);

    // Grant withheld for three cycles
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk1("nogrant_req", bus.imem_req, 1'b1);
    chk("nogrant_addr", bus.imem_addr, 32'h8);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk1("granted_req", bus.imem_req, 1'b0);

    // Redirect while PC 8 is outstanding
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0103);
    chk1("redir_valid", instr_valid, 1'b0);
    chk("redir_addr", bus.imem_addr, 32'h100);
    step(1'b0, 1'b1, 32'h0000_8888, 1'b1, 1'b0, 32'h0);
    chk1("dropped_valid", instr_valid, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    chk("redir_pc", InstrPC, 32'h100);
    chk("redir_instr", Instr, 32'h1234_5678);

    // Reset in the middle of WAIT, then a late response
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    pulse_reset();
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    chk1("late_valid", instr_valid, 1'b0);
    chk("late_addr", bus.imem_addr, RESET_PC);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
    chk("restart_instr", Instr, 32'h0050_0093);
    chk("restart_pc", InstrPC, RESET_PC);

    // Redirect to the top word and wrap
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    step(1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0);
    chk("top_pc", InstrPC, 32'hFFFF_FFFC);
    chk1("wrap_req", bus.imem_req, 1'b1);

    // Randomized traffic
    pulse_reset();
    pend.delete();
    for (int i = 0; i < 3000; i++) begin
      g  = ($urandom_range(0, 3) != 0);
      rd = $urandom;
      if (pend.size() > 0) rv = $urandom_range(0, 1) == 1;
      else                 rv = $urandom_range(0, 15) == 0;
      step(g, rv, rd, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
    end
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
